// File: rtl/imem_sync.sv
// imem_sync: byte-addressed instruction memory, big-endian word fetch over valid/ready.
// Define IMEM_ALIGN_CHECK_EN to zero misaligned fetches and flag them on rsp_err.
module imem_sync #(
  parameter int ADDR_BUS_WIDTH = 5,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int WAIT_STATES    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_BUS_WIDTH-1:0] rsp_data,
  output logic                      rsp_err,
  input  logic                      load_en,
  input  logic [ADDR_BUS_WIDTH-1:0] load_addr,
  input  logic [7:0]                load_data
);

  localparam int DEPTH = 2 ** ADDR_BUS_WIDTH;
  localparam int LANES = DATA_BUS_WIDTH / 8;

  typedef logic [ADDR_BUS_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  addr_t                     addr_q, addr_d;
  logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
  logic                      err_q, err_d;

  logic                      accept;
  addr_t                     rd_addr;
  logic [DATA_BUS_WIDTH-1:0] word;
  logic [DATA_BUS_WIDTH-1:0] cap_data;
  logic                      err_cap;

  logic [7:0] mem [DEPTH] = '{default: 8'h00};

  // Storage is never reset; loads are ignored only while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  assign req_ready = rst_n &&
                     (state_q == IDLE ||
                      (state_q == RESP && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign rd_addr   = (state_q == WAIT) ? addr_q : req_addr;

  always_comb begin
    word = '0;
    for (int i = 0; i < LANES; i++) begin
      word[DATA_BUS_WIDTH-1-8*i -: 8] =
        mem[rd_addr + addr_t'(i)];
    end
  end

`ifdef IMEM_ALIGN_CHECK_EN
  localparam addr_t ALIGN_MASK =
    addr_t'((1 << $clog2(LANES)) - 1);
  assign err_cap = (rd_addr & ALIGN_MASK) != '0;
`else
  assign err_cap = 1'b0;
`endif

  assign cap_data = err_cap ? '0 : word;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    if (accept) begin
      addr_d = req_addr;
      if (WAIT_STATES == 0) begin
        state_d = RESP;
        data_d  = cap_data;
        err_d   = err_cap;
      end else begin
        state_d = WAIT;
        cnt_d   = 4'(WAIT_STATES);
      end
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
    end else if (state_q == WAIT) begin
      if (cnt_q == 4'd1) begin
        state_d = RESP;
        cnt_d   = '0;
        data_d  = cap_data;
        err_d   = err_cap;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: two instances (0 and 3 wait states) checked against a byte-array model.
// Expected words are assembled from the model bytes; honours IMEM_ALIGN_CHECK_EN.
module tb_imem_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv0 = 1'b0, rv3 = 1'b0;
  logic        rr0 = 1'b0, rr3 = 1'b0;
  logic [4:0]  ra = '0;
  logic        le = 1'b0;
  logic [4:0]  la = '0;
  logic [7:0]  ld = '0;
  logic        rdy0, vld0, err0;
  logic        rdy3, vld3, err3;
  logic [31:0] dat0, dat3;

  logic [7:0]  mem_m [32];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  imem_sync #(
    .ADDR_BUS_WIDTH(5),
    .DATA_BUS_WIDTH(32),
    .WAIT_STATES(0)
  ) u_ws0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv0), .req_ready(rdy0), .req_addr(ra),
    .rsp_valid(vld0), .rsp_ready(rr0),
    .rsp_data(dat0), .rsp_err(err0),
    .load_en(le), .load_addr(la), .load_data(ld)
  );

  imem_sync #(
    .ADDR_BUS_WIDTH(5),
    .DATA_BUS_WIDTH(32),
    .WAIT_STATES(3)
  ) u_ws3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv3), .req_ready(rdy3), .req_addr(ra),
    .rsp_valid(vld3), .rsp_ready(rr3),
    .rsp_data(dat3), .rsp_err(err3),
    .load_en(le), .load_addr(la), .load_data(ld)
  );

  // {err, data} expected for a fetch at byte address a
  function automatic logic [32:0] model(input logic [4:0] a);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w = {w[23:0], mem_m[5'(a + i)]};
`ifdef IMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) return {1'b1, 32'h0};
`endif
    return {1'b0, w};
  endfunction

  task automatic do_load(input logic [4:0] a, input logic [7:0] d);
    la = a; ld = d; le = 1'b1;
    @(posedge clk); #1;
    le = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic fetch(input bit w3, input logic [4:0] a, input int hold,
                       output logic [31:0] d, output logic e, output int lat);
    int n;
    ra = a;
    rr0 = 1'b0; rr3 = 1'b0;
    if (w3) rv3 = 1'b1; else rv0 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(w3 ? rdy3 : rdy0) && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rv0 = 1'b0; rv3 = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!(w3 ? vld3 : vld0) && lat < 40) begin @(negedge clk); lat++; end
    d = w3 ? dat3 : dat0;
    e = w3 ? err3 : err0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_chk++;
      if ((w3 ? dat3 : dat0) !== d || (w3 ? err3 : err0) !== e ||
          (w3 ? vld3 : vld0) !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_stable: got data %h err %b valid %b, want data %h err %b valid 1",
                 w3 ? dat3 : dat0, w3 ? err3 : err0, w3 ? vld3 : vld0, d, e);
      end
    end
    if (w3) rr3 = 1'b1; else rr0 = 1'b1;
    @(posedge clk); #1;
    rr0 = 1'b0; rr3 = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e; int lat;
    rv0 = 1'b1; rv3 = 1'b1;
    le = 1'b1; la = 5'd20; ld = 8'hAA;
    @(negedge clk); @(negedge clk);
    n_chk++;
    if ({vld0, err0, rdy0, dat0, vld3, err3, rdy3, dat3} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ws0 v%b e%b r%b %h ws3 v%b e%b r%b %h, want all 0",
               vld0, err0, rdy0, dat0, vld3, err3, rdy3, dat3);
    end
    rv0 = 1'b0; rv3 = 1'b0; le = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (rdy0 !== 1'b1 || rdy3 !== 1'b1 || vld0 !== 1'b0 || vld3 !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_reset: got rdy %b%b vld %b%b, want rdy 11 vld 00",
               rdy0, rdy3, vld0, vld3);
    end
    @(posedge clk); #1;
    fetch(1'b0, 5'd20, 0, d, e, lat);
    n_chk++;
    if (d !== model(5'd20) || d !== 32'h0) begin
      n_fail++;
      $display("FAIL load_in_reset: got %h, want 00000000", d);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic e; int lat;
    do_load(5'd4, 8'hFF); do_load(5'd5, 8'hC4);
    do_load(5'd6, 8'hA3); do_load(5'd7, 8'h03);
    fetch(1'b0, 5'd4, 0, d, e, lat);
    n_chk++;
    if (d !== 32'hFFC4A303 || e !== 1'b0 || lat !== 0) begin
      n_fail++;
      $display("FAIL basic_fetch: got %h err %b lat %0d, want FFC4A303 err 0 lat 0",
               d, e, lat);
    end
  endtask

  task automatic test_wait_backpressure();
    bit bad;
    ra = 5'd4; rv3 = 1'b1; rr3 = 1'b0;
    @(posedge clk); #1;
    ra = 5'd8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_chk++;
      bad = (vld3 !== (i >= 3)) || (rdy3 !== 1'b0) ||
            (i >= 3 && (dat3 !== 32'hFFC4A303 || err3 !== 1'b0));
      if (bad) begin
        n_fail++;
        $display("FAIL wait_bp cycle %0d: got vld %b rdy %b data %h, want vld %b rdy 0 data FFC4A303",
                 i, vld3, rdy3, dat3, i >= 3);
      end
    end
    rv3 = 1'b0; rr3 = 1'b1;
    #1;
    n_chk++;
    if (rdy3 !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_comb: got %b, want 1", rdy3);
    end
    @(posedge clk); #1;
    rr3 = 1'b0;
    @(negedge clk);
    n_chk++;
    if (vld3 !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_drop: got vld %b, want 0", vld3);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    logic [31:0] d; logic e; int lat;
    logic [32:0] m;
    do_load(5'd8, 8'h00);
    m = model(5'd5);
    fetch(1'b0, 5'd5, 1, d, e, lat);
    n_chk++;
    if (d !== m[31:0] || e !== m[32] || lat !== 0) begin
      n_fail++;
      $display("FAIL misaligned_ws0: got %h err %b lat %0d, want %h err %b lat 0",
               d, e, lat, m[31:0], m[32]);
    end
    fetch(1'b1, 5'd5, 0, d, e, lat);
    n_chk++;
    if (d !== m[31:0] || e !== m[32] || lat !== 3) begin
      n_fail++;
      $display("FAIL misaligned_ws3: got %h err %b lat %0d, want %h err %b lat 3",
               d, e, lat, m[31:0], m[32]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic e; int lat;
    logic [32:0] m;
    do_load(5'd30, 8'h11); do_load(5'd31, 8'h22);
    do_load(5'd0, 8'h33);  do_load(5'd1, 8'h44);
    m = model(5'd30);
    fetch(1'b0, 5'd30, 0, d, e, lat);
    n_chk++;
    if (d !== m[31:0] || e !== m[32]) begin
      n_fail++;
      $display("FAIL wrap: got %h err %b, want %h err %b", d, e, m[31:0], m[32]);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] m4, m8;
    m4 = model(5'd4);
    m8 = model(5'd8);
    ra = 5'd4; rv0 = 1'b1; rr0 = 1'b1;
    @(posedge clk); #1;
    ra = 5'd8;
    @(negedge clk);
    n_chk++;
    if (vld0 !== 1'b1 || dat0 !== m4[31:0] || rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: got vld %b data %h rdy %b, want 1 %h 1",
               vld0, dat0, rdy0, m4[31:0]);
    end
    @(posedge clk); #1;
    rv0 = 1'b0;
    @(negedge clk);
    n_chk++;
    if (vld0 !== 1'b1 || dat0 !== m8[31:0]) begin
      n_fail++;
      $display("FAIL b2b_second: got vld %b data %h, want 1 %h", vld0, dat0, m8[31:0]);
    end
    @(posedge clk); #1;
    rr0 = 1'b0;
    @(negedge clk);
    n_chk++;
    if (vld0 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got vld %b, want 0", vld0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] d; logic e; int lat;
    bit seen;
    ra = 5'd4; rv3 = 1'b1; rr3 = 1'b0;
    @(posedge clk); #1;
    rv3 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (vld3 !== 1'b0 || rdy3 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait_reset: got vld %b rdy %b, want 0 0", vld3, rdy3);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vld3 !== 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL dropped_request: got a response after reset, want none");
    end
    @(posedge clk); #1;
    fetch(1'b1, 5'd4, 0, d, e, lat);
    n_chk++;
    if (d !== 32'hFFC4A303 || lat !== 3) begin
      n_fail++;
      $display("FAIL mem_kept: got %h lat %0d, want FFC4A303 lat 3", d, lat);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic e; int lat;
    ra = 5'd4; rv3 = 1'b1; rr3 = 1'b0;
    @(posedge clk); #1;
    rv3 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    le = 1'b1; la = 5'd4; ld = 8'h00;
    @(posedge clk); #1;
    le = 1'b0;
    mem_m[4] = 8'h00;
    @(negedge clk);
    n_chk++;
    if (vld3 !== 1'b1 || dat3 !== 32'hFFC4A303) begin
      n_fail++;
      $display("FAIL collision_old: got vld %b data %h, want 1 FFC4A303", vld3, dat3);
    end
    rr3 = 1'b1;
    @(posedge clk); #1;
    rr3 = 1'b0;
    fetch(1'b1, 5'd4, 0, d, e, lat);
    n_chk++;
    if (d !== 32'h00C4A303 || d !== model(5'd4)) begin
      n_fail++;
      $display("FAIL collision_new: got %h, want 00C4A303", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d; logic e; int lat;
    logic [32:0] m;
    logic [4:0]  a;
    bit          w;
    int          hold;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(1, 0) == 1)
        do_load(5'($urandom_range(31, 0)), 8'($urandom));
      a    = 5'($urandom_range(31, 0));
      w    = 1'($urandom_range(1, 0));
      hold = int'($urandom_range(3, 0));
      m    = model(a);
      fetch(w, a, hold, d, e, lat);
      n_chk++;
      if (d !== m[31:0] || e !== m[32]) begin
        n_fail++;
        $display("FAIL rand_data it %0d addr %0d: got %h err %b, want %h err %b",
                 it, a, d, e, m[31:0], m[32]);
      end
      n_chk++;
      if (lat !== (w ? 3 : 0)) begin
        n_fail++;
        $display("FAIL rand_latency it %0d: got %0d, want %0d", it, lat, w ? 3 : 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem_m[i] = 8'h00;
    test_reset();
    test_basic();
    test_wait_backpressure();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_reset_mid_wait();
    test_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
